// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the snake game datapath and its controller.
// The datapath side uses the master modport, the controller uses slave.
interface snake_game_ctrl_if;
    logic        enable;
    logic        up_btn;
    logic        down_btn;
    logic        left_btn;
    logic        right_btn;
    logic        frame_start;
    logic        collision;
    logic        food_eaten;
    logic [15:0] rnd_i;
    logic [1:0]  dir;
    logic        move_tick;
    logic        grow;
    logic        food_load;
    logic [5:0]  food_x;
    logic [4:0]  food_y;
    logic [1:0]  state;
    logic [7:0]  score;

    modport master (
        output enable, up_btn, down_btn, left_btn, right_btn,
        output frame_start, collision, food_eaten, rnd_i,
        input  dir, move_tick, grow, food_load, food_x, food_y, state, score
    );

    modport slave (
        input  enable, up_btn, down_btn, left_btn, right_btn,
        input  frame_start, collision, food_eaten, rnd_i,
        output dir, move_tick, grow, food_load, food_x, food_y, state, score
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game controller: button edge handling, move pacing, growth/food
// sequencing and score keeping. All outputs come straight from registers.
module snake_game_ctrl #(
    parameter int FRAMES_PER_MOVE = 8,
    parameter int MIN_FRAMES      = 2,
    parameter int FOOD_COLS       = 40,
    parameter int FOOD_ROWS       = 30
) (
    input logic              clk,
    input logic              rst,
    snake_game_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(FRAMES_PER_MOVE + 1);
    localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(FRAMES_PER_MOVE);
    localparam logic [CNT_W-1:0] PERIOD_MIN  = CNT_W'(MIN_FRAMES);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_GROW = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    // Encoding pairs up/down and left/right, so flipping bit 0 reverses.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction

    function automatic logic [5:0] wrap_col(input logic [5:0] raw);
        if (raw >= 6'(FOOD_COLS)) return raw - 6'(FOOD_COLS);
        else                      return raw;
    endfunction

    function automatic logic [4:0] wrap_row(input logic [4:0] raw);
        if (raw >= 5'(FOOD_ROWS)) return raw - 5'(FOOD_ROWS);
        else                      return raw;
    endfunction

    state_t           state_r;
    logic [1:0]       dir_r;
    logic [1:0]       pend_r;
    logic             move_tick_r;
    logic             grow_r;
    logic             food_load_r;
    logic [5:0]       food_x_r;
    logic [4:0]       food_y_r;
    logic [7:0]       score_r;
    logic [CNT_W-1:0] frame_cnt_r;
    logic [CNT_W-1:0] period_r;
    logic [3:0]       btn_prev_r;

    logic [3:0]       btn_s;
    logic [3:0]       edge_s;
    logic             any_edge_s;
    logic [1:0]       win_dir_s;
    logic             accept_s;
    logic [1:0]       pend_next_s;
    logic             tick_due_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Edge detection, direction arbitration and frame pacing decisions.
    always_comb begin
        btn_s      = {bus.up_btn, bus.down_btn, bus.left_btn, bus.right_btn};
        edge_s     = btn_s & ~btn_prev_r;
        any_edge_s = |edge_s;
        if (edge_s[3])      win_dir_s = DIR_UP;
        else if (edge_s[2]) win_dir_s = DIR_DOWN;
        else if (edge_s[1]) win_dir_s = DIR_LEFT;
        else                win_dir_s = DIR_RIGHT;
        accept_s    = any_edge_s && (win_dir_s != opposite_dir(dir_r));
        pend_next_s = accept_s ? win_dir_s : pend_r;
        // ">=" covers a period that shrank below the running count.
        tick_due_s  = bus.frame_start && (frame_cnt_r >= (period_r - CNT_W'(1)));
        if (!bus.frame_start) cnt_next_s = frame_cnt_r;
        else if (tick_due_s)  cnt_next_s = {CNT_W{1'b0}};
        else                  cnt_next_s = frame_cnt_r + CNT_W'(1);
    end

    // Game state machine with all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            dir_r       <= DIR_RIGHT;
            pend_r      <= DIR_RIGHT;
            move_tick_r <= 1'b0;
            grow_r      <= 1'b0;
            food_load_r <= 1'b0;
            food_x_r    <= 6'd0;
            food_y_r    <= 5'd0;
            score_r     <= 8'd0;
            frame_cnt_r <= {CNT_W{1'b0}};
            period_r    <= PERIOD_INIT;
            btn_prev_r  <= 4'b0000;
        end else if (!bus.enable) begin
            move_tick_r <= 1'b0;
            grow_r      <= 1'b0;
            food_load_r <= 1'b0;
        end else begin
            btn_prev_r  <= btn_s;
            move_tick_r <= 1'b0;
            grow_r      <= 1'b0;
            food_load_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_edge_s) begin
                        dir_r       <= win_dir_s;
                        pend_r      <= win_dir_s;
                        score_r     <= 8'd0;
                        frame_cnt_r <= {CNT_W{1'b0}};
                        period_r    <= PERIOD_INIT;
                        state_r     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.collision) begin
                        state_r <= ST_OVER;
                    end else begin
                        pend_r      <= pend_next_s;
                        frame_cnt_r <= cnt_next_s;
                        if (tick_due_s) begin
                            move_tick_r <= 1'b1;
                            dir_r       <= pend_next_s;
                        end
                        if (bus.food_eaten) begin
                            state_r     <= ST_GROW;
                            grow_r      <= 1'b1;
                            food_load_r <= 1'b1;
                            food_x_r    <= wrap_col(bus.rnd_i[5:0]);
                            food_y_r    <= wrap_row(bus.rnd_i[12:8]);
                            score_r     <= (score_r == 8'hFF) ? 8'hFF : score_r + 8'd1;
                            period_r    <= (period_r > PERIOD_MIN) ? period_r - CNT_W'(1) : PERIOD_MIN;
                        end
                    end
                end
                ST_GROW: begin
                    // Button edges are dropped here; frames keep counting.
                    state_r     <= ST_RUN;
                    frame_cnt_r <= cnt_next_s;
                    if (tick_due_s) begin
                        move_tick_r <= 1'b1;
                        dir_r       <= pend_r;
                    end
                end
                ST_OVER: begin
                    if (any_edge_s) state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.dir       = dir_r;
    assign bus.move_tick = move_tick_r;
    assign bus.grow      = grow_r;
    assign bus.food_load = food_load_r;
    assign bus.food_x    = food_x_r;
    assign bus.food_y    = food_y_r;
    assign bus.state     = state_r;
    assign bus.score     = score_r;

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 Parameter FRAMES_PER_MOVE, default 8, frames between moves at game start.
REQ-002 Parameter MIN_FRAMES, default 2, fastest move period in frames.
REQ-003 Parameter FOOD_COLS, default 40, grid columns (range 33..63).
REQ-004 Parameter FOOD_ROWS, default 30, grid rows (range 17..31).
REQ-005 Port clk  in  1  pixel clock (divided clock); all logic on rising edge.
REQ-006 Port rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-007 Port enable  in  1  high = run; low = freeze all state, no pulses.
REQ-008 Ports up_btn, down_btn, left_btn, right_btn  in  1 each  debounced button levels.
REQ-009 Port frame_start  in  1  one-cycle pulse per VGA frame.
REQ-010 Port collision  in  1  snake head hit wall or body (level, sampled in RUN).
REQ-011 Port food_eaten  in  1  head on food (level, sampled in RUN).
REQ-012 Port rnd_i  in  16  free-running LFSR value.
REQ-013 Port dir  out  2  current direction: 00 up, 01 down, 10 left, 11 right.
REQ-014 Port move_tick  out  1  one-cycle pulse: datapath advances snake one cell.
REQ-015 Port grow  out  1  one-cycle pulse: datapath lengthens snake by one.
REQ-016 Port food_load  out  1  one-cycle pulse: food_x/food_y valid, load new food.
REQ-017 Ports food_x  out  6, food_y  out  5  new food cell.
REQ-018 Port state  out  2  00 IDLE, 01 RUN, 10 GROW, 11 OVER.
REQ-019 Port score  out  8  food eaten this game.

Function
REQ-020 Each button SHALL be rising-edge detected via a registered previous level; only edges act.
REQ-021 Simultaneous edges SHALL be resolved by priority up > down > left > right; only the winner acts.
REQ-022 In RUN, an edge requesting the reverse of dir SHALL be ignored; otherwise it SHALL overwrite the pending direction register.
REQ-023 dir SHALL take the pending value on the cycle move_tick is asserted, never elsewhere in RUN.
REQ-024 IDLE: an edge SHALL set dir and pending to the winning direction (no reverse rule), clear score, clear frame counter, load period = FRAMES_PER_MOVE, go to RUN next cycle.
REQ-025 RUN: frame counter SHALL increment on frame_start; when frame_start arrives with counter = period-1, move_tick SHALL be 1 the next cycle and counter SHALL return to 0.
REQ-026 RUN: collision = 1 SHALL go to OVER next cycle; collision has priority over food_eaten and over a coincident move_tick (no tick issued).
REQ-027 RUN: food_eaten = 1 (no collision) SHALL go to GROW next cycle.
REQ-028 GROW lasts exactly one cycle: grow = 1, food_load = 1, score += 1 saturating at 255, period -= 1 saturating at MIN_FRAMES, then RUN.
REQ-029 food_x SHALL be rnd_i[5:0], minus FOOD_COLS if >= FOOD_COLS; food_y SHALL be rnd_i[12:8], minus FOOD_ROWS if >= FOOD_ROWS; registered on GROW entry.
REQ-030 Frame counter and pending direction SHALL keep their values through GROW; a frame_start during GROW SHALL still be counted.
REQ-031 OVER: no pulses; dir and score held; any button edge SHALL go to IDLE next cycle.
REQ-032 enable = 0 SHALL hold every register (including edge-detect history) and force move_tick, grow, food_load to 0.

Reset
REQ-033 rst = 1 at a clock edge SHALL set: state IDLE, dir 11, pending 11, move_tick 0, grow 0, food_load 0, food_x 0, food_y 0, score 0, frame counter 0, period FRAMES_PER_MOVE, button history 0.
REQ-034 rst SHALL override enable and every other input, including mid-GROW or mid-tick.

Verification
REQ-035 Reset, up edge in IDLE -> state RUN, dir 00; 8th frame_start -> move_tick 1 cycle later, single cycle.
REQ-036 RUN dir 11, left edge then up edge before tick -> left ignored, dir 00 after next move_tick.
REQ-037 Up and left edges same cycle in IDLE -> dir 00.
REQ-038 food_eaten with rnd_i = 16'h1F2D -> GROW one cycle, grow = food_load = 1, food_x 5, food_y 1, score 1, period 7; seven GROWs total -> period stays 2.
REQ-039 collision and food_eaten same cycle -> OVER, score unchanged, no grow; then right edge -> IDLE.
REQ-040 enable = 0 across frame_start pulses and button edges -> no state change; rst mid-RUN -> all REQ-033 values next cycle.
